// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU.
// Single-cycle ops complete in one cycle. MULTU (shift-add) and DIVU
// (restoring division) iterate one bit per cycle. Results are held in
// registers until the next completion.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alu_Control,
  input  logic [WIDTH-1:0] src_A,
  input  logic [WIDTH-1:0] src_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_Result,
  output logic [WIDTH-1:0] alu_Hi,
  output logic             alu_Zero,
  output logic             alu_Error
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1111;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // Shared iteration registers:
  //   MUL: acc_hi = partial product high, acc_lo = multiplier/low product, opnd = multiplicand
  //   DIV: acc_hi = partial remainder, acc_lo = dividend/quotient, opnd = divisor
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             zero_q, err_q;

  logic [WIDTH-1:0] c_res, c_hi;
  logic             c_err;
  logic [SHW-1:0]   shamt;

  // Single-cycle result straight from the inputs; only used on accept.
  always_comb begin
    shamt = src_B[SHW-1:0];
    c_res = '0;
    c_hi  = '0;
    c_err = 1'b0;
    case (alu_Control)
      OP_AND:   c_res = src_A & src_B;
      OP_OR:    c_res = src_A | src_B;
      OP_ADD:   c_res = src_A + src_B;
      OP_SLL:   c_res = src_A << shamt;
      OP_SRL:   c_res = src_A >> shamt;
      OP_XOR:   c_res = src_A ^ src_B;
      OP_SUB:   c_res = src_A - src_B;
      OP_SLT:   c_res = {{(WIDTH-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
      OP_SRA:   c_res = WIDTH'($signed(src_A) >>> shamt);
      OP_SLTU:  c_res = {{(WIDTH-1){1'b0}}, (src_A < src_B)};
      // Reached only for a zero divisor: no iteration needed.
      OP_DIVU: begin
        c_res = '1;
        c_hi  = src_A;
      end
      OP_MULTU: c_res = '0;
      default:  c_err = 1'b1;
    endcase
  end

  logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic             last;

  // One shift-add step and one restoring-division step.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, opnd};
    // Top bit of the difference is the borrow: set means remainder < divisor.
    if (!rem_sub[WIDTH]) begin
      div_hi_n = rem_sub[WIDTH-1:0];
      div_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_n = rem_sh[WIDTH-1:0];
      div_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
    end
    last = (cnt == CW'(1));
  end

  // FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      res_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (alu_Control == OP_MULTU) begin
              acc_hi <= '0;
              acc_lo <= src_B;
              opnd   <= src_A;
              cnt    <= CW'(WIDTH);
              state  <= S_MUL;
            end else if (alu_Control == OP_DIVU && src_B != '0) begin
              acc_hi <= '0;
              acc_lo <= src_A;
              opnd   <= src_B;
              cnt    <= CW'(WIDTH);
              state  <= S_DIV;
            end else begin
              res_q  <= c_res;
              hi_q   <= c_hi;
              zero_q <= (c_res == '0);
              err_q  <= c_err;
              state  <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          cnt    <= cnt - CW'(1);
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          if (last) begin
            res_q  <= mul_lo_n;
            hi_q   <= mul_hi_n;
            zero_q <= (mul_lo_n == '0);
            err_q  <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DIV: begin
          cnt    <= cnt - CW'(1);
          acc_hi <= div_hi_n;
          acc_lo <= div_lo_n;
          if (last) begin
            res_q  <= div_lo_n;
            hi_q   <= div_hi_n;
            zero_q <= (div_lo_n == '0);
            err_q  <= 1'b0;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state == S_MUL) || (state == S_DIV);
  assign done       = (state == S_DONE);
  assign alu_Result = res_q;
  assign alu_Hi     = hi_q;
  assign alu_Zero   = zero_q;
  assign alu_Error  = err_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed corner cases plus randomized ops checked against
// an arithmetic reference model.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, err;
  logic [31:0] res, hi;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .alu_Control(op),
    .src_A(a), .src_B(b), .busy(busy), .done(done),
    .alu_Result(res), .alu_Hi(hi), .alu_Zero(zero), .alu_Error(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results from plain arithmetic, latency from op class.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [31:0] h,
                                output logic e, output int lat);
    logic [63:0] p;
    r = 0; h = 0; e = 0; lat = 1;
    case (o)
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'h2: r = x + y;
      4'h3: r = x << y[4:0];
      4'h4: r = x >> y[4:0];
      4'h5: r = x ^ y;
      4'h6: r = x - y;
      4'h7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h8: begin
        p = 64'(x) * 64'(y);
        r = p[31:0]; h = p[63:32]; lat = 33;
      end
      4'h9: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; h = x; end
        else begin r = x / y; h = x % y; lat = 33; end
      end
      4'hA: r = 32'($signed(x) >>> y[4:0]);
      4'hF: r = (x < y) ? 32'd1 : 32'd0;
      default: e = 1;
    endcase
  endfunction

  // Issue one op, disturb inputs while busy, check latency and results.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] er, eh;
    logic        ee;
    int          elat, lat, nbusy;
    model(o, x, y, er, eh, ee, elat);
    start = 1; op = o; a = x; b = y;
    lat = 0; nbusy = 0;
    do begin
      tick();
      lat++;
      if (done) break;
      if (busy) begin
        nbusy++;
        start = 1'($urandom_range(1, 0));
        op = 4'($urandom); a = $urandom; b = $urandom;
      end else start = 0;
    end while (lat < 60);
    start = 0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_busy"}, 64'(nbusy), 64'(elat - 1));
    chk({tag, "_res"}, 64'(res), 64'(er));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_zero"}, 64'(zero), 64'(er == 0));
    chk({tag, "_err"}, 64'(err), 64'(ee));
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'(0));
    chk({tag, "_hold"}, {hi, res}, {eh, er});
  endtask

  initial begin
    logic [3:0] ro;
    logic [31:0] ra, rb;
    int seen;
    reset_n = 0; start = 0; op = 0; a = 0; b = 0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_out", {hi, res}, 0);
    chk("rst_zero", 64'(zero), 1);
    chk("rst_err", 64'(err), 0);
    reset_n = 1;
    tick();

    run_op(4'h2, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    run_op(4'h7, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(4'hF, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(4'hA, 32'h8000_0000, 32'h24, "sra");
    run_op(4'h3, 32'h0000_0001, 32'hFFFF_FFFF, "sll31");
    run_op(4'h4, 32'h8000_0000, 32'h20, "srl0");
    run_op(4'h6, 32'd0, 32'd1, "sub_wrap");
    run_op(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    run_op(4'h9, 32'd100, 32'd7, "div");
    run_op(4'h9, 32'd5, 32'd0, "div0");
    run_op(4'h9, 32'd3, 32'd9, "div_small");
    run_op(4'hB, 32'h1234, 32'h5678, "illegal");
    run_op(4'h8, 32'd0, 32'h1234_5678, "mul_zero");

    // Back-to-back: start held through DIVU, AND issued in the DONE cycle.
    start = 1; op = 4'h9; a = 32'd100; b = 32'd7;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin seen = 1; break; end
    end
    chk("b2b_first", 64'(seen), 1);
    chk("b2b_div", {hi, res}, {32'd2, 32'd14});
    op = 4'h0; a = 32'hF0F0_1234; b = 32'h0FF0_FF00;
    tick();
    start = 0;
    chk("b2b_second", 64'(done), 1);
    chk("b2b_and", {hi, res}, {32'd0, 32'h00F0_1200});
    tick();

    // Reset part-way through a multiply; reset also beats a same-edge start.
    run_op(4'h8, 32'hFFFF_FFFF, 32'h3, "mul_pre");
    start = 1; op = 4'h8; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    tick();
    start = 0;
    repeat (9) tick();
    reset_n = 0; start = 1; op = 4'h2; a = 32'd1; b = 32'd2;
    tick();
    start = 0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_out", {hi, res}, 0);
    chk("abort_zero", 64'(zero), 1);
    chk("abort_err", 64'(err), 0);
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1;
    end
    chk("abort_quiet", 64'(seen), 0);

    // Randomized ops, biased toward legal codes and small / zero divisors.
    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(3, 0))
        0: rb = 32'($urandom_range(15, 0));
        1: ra = 32'($urandom_range(255, 0));
        default: ;
      endcase
      if ($urandom_range(3, 0) == 0) ro = ($urandom_range(1, 0) != 0) ? 4'h8 : 4'h9;
      run_op(ro, ra, rb, $sformatf("rnd%0d_op%0h", i, ro));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
